proc_ctrl: RTL and testbench

Instruction-cycle controller for the s_proc_v1 accumulator processor. It replaces the free-running T-state generator with a stallable one-hot T-state sequencer and decodes the current T-state and the IR opcode into the per-cycle datapath control strobes. It waits on a memory-ready handshake and halts on HLT or on a memory timeout. It sits between the IR/memory and the PC, MAR, A, B, ALU and OUT registers.

---
 rtl/proc_ctrl_pkg.sv | 43 ++++
 rtl/proc_ctrl_dec.sv | 49 ++++
 rtl/proc_ctrl.sv | 128 ++++++++++++
 tb/tb_proc_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the s_proc_v1 instruction-cycle controller:
// opcode values, one-hot T-state encoding and the strobe vector bit order.
package proc_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam int unsigned N_STB     = 12;
  localparam int unsigned S_PC_OE   = 0;
  localparam int unsigned S_PC_INC  = 1;
  localparam int unsigned S_MAR_LD  = 2;
  localparam int unsigned S_MEM_RD  = 3;
  localparam int unsigned S_IR_LD   = 4;
  localparam int unsigned S_IR_OE   = 5;
  localparam int unsigned S_A_LD    = 6;
  localparam int unsigned S_A_OE    = 7;
  localparam int unsigned S_B_LD    = 8;
  localparam int unsigned S_ALU_OE  = 9;
  localparam int unsigned S_ALU_SUB = 10;
  localparam int unsigned S_OUT_LD  = 11;

  // Instructions that fetch an operand from memory in T5.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_ctrl_dec.sv
// Combinational strobe decoder: (T-state, opcode, mem_rdy) to the raw strobe
// vector. Enable/halt gating is applied by the parent.
module proc_ctrl_dec
  import proc_ctrl_pkg::*;
(
  input  tstate_e          state_i,
  input  logic [3:0]       opcode_i,
  input  logic             mem_rdy_i,
  output logic [N_STB-1:0] strobe_o
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    strobe_o = '0;
    case (state_i)
      T1: begin
        strobe_o[S_PC_OE]  = 1'b1;
        strobe_o[S_MAR_LD] = 1'b1;
      end
      T2: strobe_o[S_PC_INC] = 1'b1;
      T3: begin
        strobe_o[S_MEM_RD] = 1'b1;
        strobe_o[S_IR_LD]  = mem_rdy_i;
      end
      T4: begin
        if (is_mem_op(opcode_i)) begin
          strobe_o[S_IR_OE]  = 1'b1;
          strobe_o[S_MAR_LD] = 1'b1;
        end else if (opcode_i == OP_OUT) begin
          strobe_o[S_A_OE]   = 1'b1;
          strobe_o[S_OUT_LD] = 1'b1;
        end
      end
      T5: begin
        strobe_o[S_MEM_RD] = 1'b1;
        strobe_o[S_A_LD]   = mem_rdy_i & (opcode_i == OP_LDA);
        strobe_o[S_B_LD]   = mem_rdy_i & is_alu_op(opcode_i);
      end
      T6: begin
        strobe_o[S_ALU_OE]  = 1'b1;
        strobe_o[S_A_LD]    = 1'b1;
        strobe_o[S_ALU_SUB] = (opcode_i == OP_SUB);
      end
      default: strobe_o = '0;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// Stallable one-hot T-state sequencer for s_proc_v1 with memory-ready wait,
// timeout error halt and HLT handling; strobes come from proc_ctrl_dec.
module proc_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ce,
  input  logic [3:0] opcode,
  input  logic       mem_rdy,
  output logic [5:0] state,
  output logic       pc_oe,
  output logic       pc_inc,
  output logic       mar_ld,
  output logic       mem_rd,
  output logic       ir_ld,
  output logic       ir_oe,
  output logic       a_ld,
  output logic       a_oe,
  output logic       b_ld,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_ld,
  output logic       halted,
  output logic       err
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  tstate_e          state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [N_STB-1:0] raw_stb, stb;
  logic             run;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    err_d    = err_q;
    if (ce) begin
      // The counter only survives a cycle spent waiting; anything else clears it.
      wait_d = '0;
      if (halted_q) begin
        state_d = T1;
      end else begin
        case (state_q)
          T1: state_d = T2;
          T2: state_d = T3;
          T3: begin
            if (mem_rdy) begin
              state_d = T4;
            end else if (wait_q >= LAST_WAIT) begin
              state_d  = T1;
              halted_d = 1'b1;
              err_d    = 1'b1;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end
          T4: begin
            state_d = is_mem_op(opcode) ? T5 : T1;
            if (opcode == OP_HLT) halted_d = 1'b1;
          end
          T5: begin
            if (mem_rdy) begin
              state_d = is_alu_op(opcode) ? T6 : T1;
            end else if (wait_q >= LAST_WAIT) begin
              state_d  = T1;
              halted_d = 1'b1;
              err_d    = 1'b1;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= T1;
      wait_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  proc_ctrl_dec u_dec (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .mem_rdy_i (mem_rdy),
    .strobe_o  (raw_stb)
  );

  assign run = ce & ~halted_q & clr;
  assign stb = raw_stb & {N_STB{run}};

  assign state   = state_q;
  assign pc_oe   = stb[S_PC_OE];
  assign pc_inc  = stb[S_PC_INC];
  assign mar_ld  = stb[S_MAR_LD];
  assign mem_rd  = stb[S_MEM_RD];
  assign ir_ld   = stb[S_IR_LD];
  assign ir_oe   = stb[S_IR_OE];
  assign a_ld    = stb[S_A_LD];
  assign a_oe    = stb[S_A_OE];
  assign b_ld    = stb[S_B_LD];
  assign alu_oe  = stb[S_ALU_OE];
  assign alu_sub = stb[S_ALU_SUB];
  assign out_ld  = stb[S_OUT_LD];
  assign halted  = halted_q;
  assign err     = err_q;

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: instruction scripts expanded into
// expected per-enabled-cycle records, replayed with random ce stalls.
module tb_proc_ctrl;

  localparam int TO = 4;

  // Bench-side strobe order, matching the obs concatenation below.
  localparam logic [11:0] B_PC_OE   = 12'h800;
  localparam logic [11:0] B_PC_INC  = 12'h400;
  localparam logic [11:0] B_MAR_LD  = 12'h200;
  localparam logic [11:0] B_MEM_RD  = 12'h100;
  localparam logic [11:0] B_IR_LD   = 12'h080;
  localparam logic [11:0] B_IR_OE   = 12'h040;
  localparam logic [11:0] B_A_LD    = 12'h020;
  localparam logic [11:0] B_A_OE    = 12'h010;
  localparam logic [11:0] B_B_LD    = 12'h008;
  localparam logic [11:0] B_ALU_OE  = 12'h004;
  localparam logic [11:0] B_ALU_SUB = 12'h002;
  localparam logic [11:0] B_OUT_LD  = 12'h001;

  logic       clk, clr, ce, mem_rdy;
  logic [3:0] opcode;
  logic [5:0] state;
  logic pc_oe, pc_inc, mar_ld, mem_rd, ir_ld, ir_oe, a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld;
  logic halted, err;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;      // T-state number 1..6
    logic [11:0] stb;
    logic       rdy;
    logic [3:0] op;
    logic       hlt;
    logic       er;
    int         hold;   // forced ce=0 cycles before this record is consumed
  } rec_t;

  rec_t q[$];
  logic halted_m, err_m;

  proc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .ce(ce), .opcode(opcode), .mem_rdy(mem_rdy),
    .state(state), .pc_oe(pc_oe), .pc_inc(pc_inc), .mar_ld(mar_ld),
    .mem_rd(mem_rd), .ir_ld(ir_ld), .ir_oe(ir_oe), .a_ld(a_ld), .a_oe(a_oe),
    .b_ld(b_ld), .alu_oe(alu_oe), .alu_sub(alu_sub), .out_ld(out_ld),
    .halted(halted), .err(err)
  );

  assign obs = {pc_oe, pc_inc, mar_ld, mem_rd, ir_ld, ir_oe, a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(15));
  endfunction

  function automatic logic [5:0] onehot(input int t);
    logic [5:0] one;
    one = 6'd1;
    return one << (t - 1);
  endfunction

  // ---------------- reference model: instruction -> cycle records ----------
  task automatic push(input int t, input logic [11:0] stb, input logic rdy, input logic [3:0] op);
    rec_t r;
    r.t = t; r.stb = halted_m ? 12'h000 : stb; r.rdy = rdy; r.op = op;
    r.hlt = halted_m; r.er = err_m; r.hold = 0;
    q.push_back(r);
  endtask

  // A memory read with w not-ready cycles; a timeout fires after TO of them.
  task automatic add_read(input int t, input logic [11:0] done_stb, input int w,
                          input logic [3:0] op, output bit ok);
    int n;
    n = (w < TO) ? w : TO;
    for (int i = 0; i < n; i++) push(t, B_MEM_RD, 1'b0, op);
    if (w >= TO) begin
      halted_m = 1'b1;
      err_m    = 1'b1;
      ok       = 1'b0;
    end else begin
      push(t, B_MEM_RD | done_stb, 1'b1, op);
      ok = 1'b1;
    end
  endtask

  task automatic add_instr(input logic [3:0] op, input int w1, input int w2);
    bit ok;
    if (halted_m) return;
    push(1, B_PC_OE | B_MAR_LD, rbit(), rop());
    push(2, B_PC_INC, rbit(), rop());
    add_read(3, B_IR_LD, w1, rop(), ok);
    if (!ok) return;
    if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
      push(4, B_IR_OE | B_MAR_LD, rbit(), op);
      add_read(5, (op == 4'h0) ? B_A_LD : B_B_LD, w2, op, ok);
      if (ok && op != 4'h0)
        push(6, B_ALU_OE | B_A_LD | ((op == 4'h2) ? B_ALU_SUB : 12'h000), rbit(), op);
    end else if (op == 4'hE) begin
      push(4, B_A_OE | B_OUT_LD, rbit(), op);
    end else begin
      push(4, 12'h000, rbit(), op);
      if (op == 4'hF) halted_m = 1'b1;
    end
  endtask

  task automatic add_halted(input int n);
    for (int i = 0; i < n; i++) push(1, 12'h000, rbit(), rop());
  endtask

  task automatic set_hold(input int t, input int n);
    for (int i = 0; i < q.size(); i++)
      if (q[i].t == t) begin
        q[i].hold = n;
        return;
      end
  endtask

  // ---------------- driver / comparator ------------------------------------
  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0; ce = 1'b0; mem_rdy = 1'b0; opcode = 4'h0;
    @(negedge clk);
    clr = 1'b1;
    halted_m = 1'b0;
    err_m    = 1'b0;
    q.delete();
  endtask

  task automatic run_script(input string name, input int ce_pct);
    int   budget;
    int   idle;
    logic ce_v;
    logic [11:0] exp_stb;
    rec_t r;
    budget = 6 * q.size() + 50;
    idle   = 0;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      r = q[0];
      if (r.hold > 0) begin
        ce_v = 1'b0;
        q[0].hold = r.hold - 1;
      end else begin
        ce_v = (idle >= 3) || (int'($urandom_range(99)) < ce_pct);
      end
      idle    = ce_v ? 0 : idle + 1;
      ce      = ce_v;
      opcode  = r.op;
      mem_rdy = ce_v ? r.rdy : rbit();
      #1;
      exp_stb = ce_v ? r.stb : 12'h000;
      checks++;
      if (state !== onehot(r.t)) begin
        errors++;
        $display("FAIL %s state: got %b expected %b", name, state, onehot(r.t));
      end
      checks++;
      if (obs !== exp_stb) begin
        errors++;
        $display("FAIL %s strobes (T%0d ce=%0b): got %h expected %h", name, r.t, ce_v, obs, exp_stb);
      end
      checks++;
      if ({halted, err} !== {r.hlt, r.er}) begin
        errors++;
        $display("FAIL %s halted/err: got %b%b expected %b%b", name, halted, err, r.hlt, r.er);
      end
      if (ce_v) void'(q.pop_front());
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s cycle budget: %0d records left, expected 0", name, q.size());
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    clr = 1'b0; ce = 1'b1; mem_rdy = 1'b1; opcode = 4'h1;
    #1;
    checks++;
    if ({state, obs, halted, err} !== {6'b000001, 12'h000, 2'b00}) begin
      errors++;
      $display("FAIL reset_hold: got st=%b stb=%h h=%b e=%b expected st=000001 stb=000 h=0 e=0", state, obs, halted, err);
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== (B_PC_OE | B_MAR_LD)) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h expected %h", obs, B_PC_OE | B_MAR_LD);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 6'b000010) begin
      errors++;
      $display("FAIL reset_first_edge: got %b expected 000010", state);
    end
  endtask

  task automatic test_lda();
    do_reset();
    for (int i = 0; i < 3; i++) add_instr(4'h0, 0, 0);
    run_script("lda", 100);
  endtask

  task automatic test_add_sub();
    do_reset();
    add_instr(4'h1, 0, 0);
    add_instr(4'h2, 0, 0);
    add_instr(4'h1, 1, 2);
    run_script("add_sub", 100);
  endtask

  task automatic test_fetch_wait();
    do_reset();
    add_instr(4'h0, 3, 0);      // ready lands on the final permitted wait cycle
    add_instr(4'h2, 2, 3);
    set_hold(3, 1);
    run_script("fetch_wait", 100);
  endtask

  task automatic test_timeout();
    do_reset();
    add_instr(4'h1, 0, TO);
    add_halted(10);
    run_script("timeout", 100);
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if ({state, halted, err} !== {6'b000001, 2'b00}) begin
      errors++;
      $display("FAIL timeout_clear: got st=%b h=%b e=%b expected st=000001 h=0 e=0", state, halted, err);
    end
    clr = 1'b1;
  endtask

  task automatic test_hlt();
    do_reset();
    add_instr(4'h0, 0, 0);
    add_instr(4'hF, 0, 0);
    add_halted(20);
    run_script("hlt", 100);
  endtask

  task automatic test_out_ce();
    do_reset();
    add_instr(4'hE, 0, 0);
    add_instr(4'h7, 0, 0);
    add_instr(4'hE, 1, 0);
    set_hold(4, 2);
    run_script("out_ce", 60);
  endtask

  task automatic test_clr_async();
    do_reset();
    ce = 1'b1; opcode = 4'h1; mem_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #2 mem_rdy = 1'b0;
    #1;
    checks++;
    if ({state, mem_rd} !== {6'b010000, 1'b1}) begin
      errors++;
      $display("FAIL clr_pre: got st=%b mem_rd=%b expected st=010000 mem_rd=1", state, mem_rd);
    end
    clr = 1'b0;
    #1;
    checks++;
    if ({state, obs} !== {6'b000001, 12'h000}) begin
      errors++;
      $display("FAIL clr_async: got st=%b stb=%h expected st=000001 stb=000", state, obs);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== (B_PC_OE | B_MAR_LD)) begin
      errors++;
      $display("FAIL clr_restart_stb: got %h expected %h", obs, B_PC_OE | B_MAR_LD);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 6'b000010) begin
      errors++;
      $display("FAIL clr_restart_edge: got %b expected 000010", state);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    int w1, w2;
    for (int round = 0; round < 8; round++) begin
      do_reset();
      for (int k = 0; k < 8 && !halted_m; k++) begin
        case ($urandom_range(9))
          0, 1:    op = 4'h0;
          2, 3:    op = 4'h1;
          4, 5:    op = 4'h2;
          6:       op = 4'hE;
          7:       op = 4'hF;
          default: op = 4'($urandom_range(3, 13));
        endcase
        w1 = ($urandom_range(9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
        w2 = ($urandom_range(9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
        add_instr(op, w1, w2);
      end
      if (halted_m) add_halted(4);
      run_script("random", 75);
    end
  endtask

  initial begin
    clr = 1'b0; ce = 1'b0; mem_rdy = 1'b0; opcode = 4'h0;
    halted_m = 1'b0; err_m = 1'b0;
    test_reset();
    test_lda();
    test_add_sub();
    test_fetch_wait();
    test_timeout();
    test_hlt();
    test_out_ce();
    test_clr_async();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
